// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding,
// row/column idle patterns and small helpers for row rotation and column pick.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  // Lowest-index column that reads low; column 0 if none (caller checks idle first).
  function automatic logic [1:0] lowest_low_col(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // One-cold rotation toward the next higher row: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  function automatic logic [3:0] next_row(input logic [3:0] row);
    return {row[2:0], row[3]};
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Free-running dwell counter for the keypad scanner. Counts 0..SCAN_DIV-1
// and raises 'sample' on the terminal count, when the columns have settled.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic sample
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end

  logic [DW-1:0] dwell_q, dwell_d;

  // Next dwell value: wrap to zero after the terminal count.
  always_comb begin
    dwell_d = dwell_q + DW'(1);
    if (dwell_q == LAST) dwell_d = '0;
  end

  // Dwell register; never paused, only cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) dwell_q <= '0;
    else       dwell_q <= dwell_d;
  end

  assign sample = (dwell_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a one-cold row select, detects a closed
// key on the sampled columns, debounces press and release, and reports the
// accepted key as row*4+col with a one-cycle key_valid pulse.
// Optional feature macro: KEYPAD_DEBOUNCE_EN enables the CONFIRM/RELEASE
// debounce states; without it a single sample accepts or releases a key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CNT must be at least 1");
  end

  logic       sample;
  state_e     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [1:0] ridx_q, ridx_d;
  logic [1:0] col_q, col_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic [1:0] low_col;
  logic       col_open;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  keypad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .sample (sample)
  );

  // Next-state, row walk, debounce counting and key capture; all decisions on sample strobes.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    ridx_d      = ridx_q;
    col_d       = col_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
    cnt_d       = cnt_q;
`endif
    low_col  = lowest_low_col(col_in);
    col_open = col_in[col_q];

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (col_in == COL_IDLE) begin
            row_d  = next_row(row_q);
            ridx_d = ridx_q + 2'd1;
          end else begin
            col_d = low_col;
`ifdef KEYPAD_DEBOUNCE_EN
            if (DEBOUNCE_CNT == 1) begin
              state_d     = ST_HELD;
              key_code_d  = {ridx_q, low_col};
              key_valid_d = 1'b1;
              cnt_d       = '0;
            end else begin
              state_d = ST_CONFIRM;
              cnt_d   = CNT_W'(1);
            end
`else
            state_d     = ST_HELD;
            key_code_d  = {ridx_q, low_col};
            key_valid_d = 1'b1;
`endif
          end
        end

`ifdef KEYPAD_DEBOUNCE_EN
        ST_CONFIRM: begin
          if (!col_open) begin
            if (cnt_q == CNT_LAST) begin
              state_d     = ST_HELD;
              key_code_d  = {ridx_q, col_q};
              key_valid_d = 1'b1;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            // Bounce or glitch: abandon this row and keep scanning.
            state_d = ST_SCAN;
            row_d   = next_row(row_q);
            ridx_d  = ridx_q + 2'd1;
            cnt_d   = '0;
          end
        end

        ST_HELD: begin
          if (col_open) begin
            if (DEBOUNCE_CNT == 1) begin
              state_d = ST_SCAN;
              row_d   = next_row(row_q);
              ridx_d  = ridx_q + 2'd1;
              cnt_d   = '0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
        end

        ST_RELEASE: begin
          if (col_open) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_SCAN;
              row_d   = next_row(row_q);
              ridx_d  = ridx_q + 2'd1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
`else
        ST_HELD: begin
          if (col_open) begin
            state_d = ST_SCAN;
            row_d   = next_row(row_q);
            ridx_d  = ridx_q + 2'd1;
          end
        end
`endif

        default: begin
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  // Control and output registers; reset wins over every pending event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      row_q       <= ROW_RESET;
      ridx_q      <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      ridx_q      <= ridx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_DEBOUNCE_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Latched column index; only meaningful once a key has been detected.
  always_ff @(posedge clk) begin
    col_q <= col_d;
  end

  assign row_out   = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
`ifdef KEYPAD_DEBOUNCE_EN
  assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);
`else
  assign key_held  = (state_q == ST_HELD);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a simulated 4x4 key matrix drives col_in from
// row_out, a sample-level behavioural model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DBE   = DEBOUNCE_CNT;
  localparam bit DB_ON = 1'b1;
`else
  localparam int DBE   = 1;
  localparam bit DB_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys  = 16'h0;
  logic [3:0]  noise = 4'h0;

  int n_pass  = 0;
  int n_total = 0;
  int vcount  = 0;
  bit m_ready = 1'b0;

  // Behavioural model state: sample-level view of the scanner.
  int m_dwell, m_row, m_col, m_run, m_code;
  bit m_locked, m_acc, m_valid;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key on the driven (low) row pulls its column low; noise models bounce.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_out[r] == 1'b0) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) col_in[c] = 1'b0;
        end
      end
    end
    col_in = col_in ^ noise;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic void accept_key();
    m_acc   = 1'b1;
    m_valid = 1'b1;
    m_code  = m_row * 4 + m_col;
    m_run   = 0;
  endfunction

  // Apply the scan/debounce rules to one clock edge.
  function automatic void model_step(input logic [3:0] c);
    bit smp;
    bit down;
    smp     = (m_dwell == SCAN_DIV - 1);
    m_dwell = (m_dwell + 1) % SCAN_DIV;
    m_valid = 1'b0;
    if (!smp) return;
    if (!m_locked) begin
      if (c != 4'hF) begin
        m_col = 0;
        for (int i = 3; i >= 0; i--) if (!c[i]) m_col = i;
        m_locked = 1'b1;
        m_acc    = 1'b0;
        m_run    = 1;
        if (m_run >= DBE) accept_key();
      end else begin
        m_row = (m_row + 1) % 4;
      end
    end else begin
      down = !c[m_col];
      if (!m_acc) begin
        if (down) begin
          m_run++;
          if (m_run >= DBE) accept_key();
        end else begin
          m_locked = 1'b0;
          m_row    = (m_row + 1) % 4;
        end
      end else begin
        if (down) m_run = 0;
        else begin
          m_run++;
          if (m_run >= DBE) begin
            m_locked = 1'b0;
            m_acc    = 1'b0;
            m_run    = 0;
            m_row    = (m_row + 1) % 4;
          end
        end
      end
    end
  endfunction

  // Per-cycle compare of all outputs against the model.
  always @(posedge clk) begin
    if (reset) begin
      m_dwell = 0; m_row = 0; m_col = 0; m_run = 0; m_code = 0;
      m_locked = 1'b0; m_acc = 1'b0; m_valid = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      model_step(col_in);
    end
    #1;
    if (key_valid === 1'b1) vcount++;
    if (m_ready) begin
      chk("row_out",   32'(row_out),   32'(4'hF ^ (4'd1 << m_row)));
      chk("key_code",  32'(key_code),  32'(m_code));
      chk("key_valid", 32'(key_valid), 32'(m_valid));
      chk("key_held",  32'(key_held),  32'(m_acc));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) for key_held to reach lvl; n = edges waited.
  task automatic wait_held(input bit lvl, input int max, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #2;
      n++;
      if (key_held === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL wait_held: key_held stayed %b, expected %0d within %0d cycles", key_held, lvl, max);
    end
  endtask

  initial begin
    bit ok;
    int n, v0;

    // Reset values and free-running row walk.
    keys = 16'h0; noise = 4'h0;
    do_reset();
    chk("rst_row",   32'(row_out),   32'(4'b1110));
    chk("rst_code",  32'(key_code),  32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held",  32'(key_held),  32'd0);
    repeat (4) @(posedge clk); #2 chk("walk_4",  32'(row_out), 32'(4'b1101));
    repeat (4) @(posedge clk); #2 chk("walk_8",  32'(row_out), 32'(4'b1011));
    repeat (4) @(posedge clk); #2 chk("walk_12", 32'(row_out), 32'(4'b0111));
    repeat (4) @(posedge clk); #2 chk("walk_16", 32'(row_out), 32'(4'b1110));

    // Key 9 (row 2, col 1): one pulse, row frozen while held, advance after release.
    do_reset();
    v0 = vcount;
    keys = 16'(1) << 9;
    wait_held(1'b1, 100, ok, n);
    chk("k9_latency", 32'(n), DB_ON ? 32'd20 : 32'd12);
    chk("k9_code",    32'(key_code), 32'd9);
    chk("k9_row",     32'(row_out),  32'(4'b1011));
    repeat (6) @(posedge clk);
    @(negedge clk);
    keys = 16'h0;
    wait_held(1'b0, 100, ok, n);
    chk("k9_row_after", 32'(row_out), 32'(4'b0111));
    chk("k9_pulses",    32'(vcount - v0), 32'd1);
    chk("k9_code_hold", 32'(key_code), 32'd9);

    // Single-sample glitch on row 0 col 2.
    do_reset();
    v0 = vcount;
    noise = 4'b0100;
    repeat (4) @(posedge clk);
    @(negedge clk);
    noise = 4'h0;
    repeat (4) @(posedge clk);
    #2 chk("glitch_row", 32'(row_out), 32'(4'b1101));
    chk("glitch_pulses", 32'(vcount - v0), DB_ON ? 32'd0 : 32'd1);

    // Two keys on row 0 (cols 1 and 3): lowest column wins.
    do_reset();
    keys = (16'(1) << 1) | (16'(1) << 3);
    wait_held(1'b1, 100, ok, n);
    chk("multi_code",    32'(key_code), 32'd1);
    chk("multi_latency", 32'(n), DB_ON ? 32'd12 : 32'd4);
    @(negedge clk);
    keys = 16'h0;
    wait_held(1'b0, 100, ok, n);

    // Key 12 (row 3, col 0).
    do_reset();
    keys = 16'(1) << 12;
    wait_held(1'b1, 100, ok, n);
    chk("k12_code",    32'(key_code), 32'd12);
    chk("k12_latency", 32'(n), DB_ON ? 32'd24 : 32'd16);
    @(negedge clk);
    keys = 16'h0;
    wait_held(1'b0, 100, ok, n);

    // Reset while held, then fresh detection of the still-pressed key 6.
    do_reset();
    keys = 16'(1) << 6;
    wait_held(1'b1, 100, ok, n);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("rh_row",   32'(row_out),   32'(4'b1110));
    chk("rh_code",  32'(key_code),  32'd0);
    chk("rh_valid", 32'(key_valid), 32'd0);
    chk("rh_held",  32'(key_held),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    v0 = vcount;
    wait_held(1'b1, 100, ok, n);
    chk("rh_redetect_code",   32'(key_code), 32'd6);
    chk("rh_redetect_pulses", 32'(vcount - v0), 32'd1);
    @(negedge clk);
    keys = 16'h0;
    wait_held(1'b0, 100, ok, n);

    // Reset in the middle of a press: no pulse for the interrupted key.
    do_reset();
    v0 = vcount;
    keys = 16'(1) << 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_pulses_before", 32'(vcount - v0), DB_ON ? 32'd0 : 32'd1);
    reset = 1'b1;
    v0 = vcount;
    @(negedge clk);
    reset = 1'b0;
    keys = 16'h0;
    repeat (30) @(posedge clk);
    #2 chk("mid_pulses_after", 32'(vcount - v0), 32'd0);

    // Randomised presses, bounce and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: keys = 16'h0;
          5, 6, 7, 8:    keys = 16'(1) << $urandom_range(0, 15);
          default:       keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
        endcase
      end
      noise = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
      reset = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    noise = 4'h0;
    repeat (4) @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
